instruction_memory_param: RTL and testbench
===========================================

# instruction_memory_param

Parametrised successor to the fixed 12-bit × 1024 instruction store. Holds the program in a synchronous single-clock RAM that is loaded through a dedicated write port. Serves PC fetches with a one-cycle read latency and a valid/ack output handshake, so the decode stage can stall fetch. Sits between the PC/fetch logic and instruction decode.

## Interface
Parameters:
- `INSTR_WIDTH`, default 12: instruction word width.
- `ADDR_WIDTH`, default 10: PC/load address width.
- `DEPTH`, default 1024: number of implemented words; must be ≤ 2^ADDR_WIDTH.
- `NOP_INSTR`, default 0: word returned for out-of-range fetches.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_instruction` in 1: asynchronous, active-high reset.
- `load_en` in 1: program-load mode request.
- `load_we` in 1: write strobe, honoured only in LOAD.
- `load_addr` in ADDR_WIDTH: write address.
- `load_data` in INSTR_WIDTH: write data.
- `fetch_req` in 1: PC presents a fetch address.
- `instruction_addr_pc` in ADDR_WIDTH: fetch address.
- `fetch_ready` out 1: fetch accepted this cycle when high with `fetch_req`.
- `instruction` out INSTR_WIDTH: fetched word, held while valid and not acked.
- `instruction_valid` out 1: `instruction` is valid.
- `instruction_ack` in 1: consumer takes `instruction` this cycle.
- `addr_error` out 1: the current valid word came from an out-of-range address.
- `parity_error` out 1: the current valid word failed its parity check. Tied 0 without the macro.

## Operation
- States: RUN and LOAD. Reset state is RUN.
- RUN → LOAD when `load_en`=1. LOAD → RUN on the first cycle `load_en`=0.
- Entering LOAD clears `instruction_valid`. Any pending word is discarded.
- In LOAD:
  - `fetch_ready`=0.
  - On `load_we`=1 with `load_addr` < DEPTH, `load_data` is written into the memory.
  - A write with `load_addr` ≥ DEPTH is ignored and has no side effects.
- In RUN:
  - `fetch_ready` = !`instruction_valid` | `instruction_ack`.
  - Accepted fetch (`fetch_req` & `fetch_ready`): the word is read and registered. The next cycle shows `instruction_valid`=1 with `instruction`, `addr_error` and `parity_error` all aligned.
  - Out-of-range fetch (`instruction_addr_pc` ≥ DEPTH): returns `NOP_INSTR` with `addr_error`=1. No memory read takes place.
  - Ack with no new accepted fetch: `instruction_valid`→0, `addr_error`/`parity_error`→0. `instruction` keeps its last value.
  - Ack and accepted fetch in the same cycle: the new word replaces the old with no bubble, which gives a throughput of one per cycle.
  - No ack: `instruction`, `instruction_valid`, `addr_error` and `parity_error` hold stable.
- Memory contents are not reset. The array keeps its data across `reset_instruction`.

## Timing
- Reset values (asynchronous, immediate):
  - state=RUN
  - `instruction`=`NOP_INSTR`
  - `instruction_valid`=0, `addr_error`=0, `parity_error`=0
  - `fetch_ready`=1 once reset is released
- Fetch latency: 1 cycle from accepting edge to `instruction_valid`.
- A load write is visible to a fetch accepted at least 1 cycle after the LOAD → RUN transition. RUN is resumed one edge after `load_en` falls.
- If reset is asserted mid-fetch, the in-flight read is dropped. No valid word appears after release until a new fetch is accepted.
- If `load_en` and `fetch_req` are both high in RUN, LOAD wins and the fetch is not accepted. `fetch_ready` is already 0 that cycle, because it is derived from the `load_en` request as well.

## Configuration
- Macro: `INSTR_MEM_PARITY_EN`.
- Defined:
  - Each word is stored with an extra even-parity bit, computed on the write port.
  - The parity is checked on read. A mismatch sets `parity_error`=1 alongside the valid word.
  - Out-of-range fetches have `parity_error`=0.
- Undefined:
  - Memory width is INSTR_WIDTH.
  - `parity_error` is constant 0.

## Test plan
- Reset with addr 0x155: `instruction`=0x000 and `instruction_valid`=0. After release, `fetch_ready`=1.
- Load: `load_en`=1, write 0xABC to 0x155, drop `load_en`. After RUN is re-entered, fetch 0x155: `instruction`=0xABC with `instruction_valid`=1 exactly 1 cycle after acceptance.
- Backpressure:
  - Load 0x001→0x111 and 0x002→0x222.
  - Fetch 0x001 and hold `instruction_ack`=0 for 3 cycles: `instruction` stays 0x111, `fetch_ready`=0.
  - Then ack with `fetch_req` on 0x002: next cycle `instruction`=0x222 with no bubble.
- Out-of-range with DEPTH=768:
  - Fetch 0x300: `instruction`=`NOP_INSTR`, `addr_error`=1.
  - A load write to 0x300 leaves words 0x000 and 0x2FF unchanged.
- Mode switch: assert `load_en` while a word is valid and unacked: `instruction_valid`→0 next cycle and `fetch_ready`=0 throughout LOAD.
- Reset mid-fetch: assert `reset_instruction` in the acceptance cycle: `instruction_valid` stays 0 after release, and loaded contents are still readable.

Source files
------------

// File: rtl/instruction_memory_param_if.sv
// Fetch/load bus for instruction_memory_param.
// The master is the PC/loader side; the slave is the instruction store.
interface instruction_memory_param_if #(
  parameter int INSTR_WIDTH = 12,
  parameter int ADDR_WIDTH  = 10
);
  logic                   load_en;
  logic                   load_we;
  logic [ADDR_WIDTH-1:0]  load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   fetch_req;
  logic [ADDR_WIDTH-1:0]  instruction_addr_pc;
  logic                   fetch_ready;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instruction_valid;
  logic                   instruction_ack;
  logic                   addr_error;
  logic                   parity_error;

  modport master (
    output load_en, load_we, load_addr, load_data,
    output fetch_req, instruction_addr_pc, instruction_ack,
    input  fetch_ready, instruction, instruction_valid,
    input  addr_error, parity_error
  );

  modport slave (
    input  load_en, load_we, load_addr, load_data,
    input  fetch_req, instruction_addr_pc, instruction_ack,
    output fetch_ready, instruction, instruction_valid,
    output addr_error, parity_error
  );
endinterface

// File: rtl/instruction_memory_param.sv
// Parametrised instruction store: loadable synchronous RAM with a 1-cycle valid/ack fetch port.
// Optional macro INSTR_MEM_PARITY_EN adds an even-parity bit per stored word.
//
//   state   | meaning
//   ST_RUN  | serving fetches, memory read-only
//   ST_LOAD | program load, fetch blocked, output invalid
module instruction_memory_param #(
  parameter int                     INSTR_WIDTH = 12,
  parameter int                     ADDR_WIDTH  = 10,
  parameter int                     DEPTH       = 1024,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic                         clk,
  input  logic                         reset_instruction,
  instruction_memory_param_if.slave    bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = INSTR_WIDTH + 1;
`else
  localparam int MEM_W = INSTR_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   addr_err_q;
  logic                   par_err_q;

  logic [MEM_W-1:0]       mem [DEPTH];
  logic [MEM_W-1:0]       wr_word;
  logic [MEM_W-1:0]       rd_word;
  logic                   rd_par_bad;
  logic                   load_in_range;
  logic                   fetch_in_range;
  logic                   fetch_ready;
  logic                   fetch_accept;
  logic                   mem_we;

  assign load_in_range  = {1'b0, bus.load_addr} < DEPTH_LIM;
  assign fetch_in_range = {1'b0, bus.instruction_addr_pc} < DEPTH_LIM;

  // load_en is folded in so a same-cycle load request always beats a fetch
  assign fetch_ready  = (state_q == ST_RUN) && !bus.load_en
                        && (!valid_q || bus.instruction_ack);
  assign fetch_accept = bus.fetch_req && fetch_ready;
  assign mem_we       = (state_q == ST_LOAD) && bus.load_we && load_in_range;

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word    = {^bus.load_data, bus.load_data};
  assign rd_par_bad = ^rd_word;
`else
  assign wr_word    = bus.load_data;
  assign rd_par_bad = 1'b0;
`endif

  // Storage has no reset so a program survives reset_instruction.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.load_addr[IDX_W-1:0]] <= wr_word;
    end
  end

  always_comb begin
    rd_word = '0;
    if (fetch_accept && fetch_in_range) begin
      rd_word = mem[bus.instruction_addr_pc[IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (bus.load_en)  state_d = ST_LOAD;
      ST_LOAD: if (!bus.load_en) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset_instruction) begin
    if (reset_instruction) begin
      state_q    <= ST_RUN;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN) begin
        if (bus.load_en) begin
          valid_q    <= 1'b0;
          addr_err_q <= 1'b0;
          par_err_q  <= 1'b0;
        end else if (fetch_accept) begin
          valid_q <= 1'b1;
          if (fetch_in_range) begin
            instr_q    <= rd_word[INSTR_WIDTH-1:0];
            addr_err_q <= 1'b0;
            par_err_q  <= rd_par_bad;
          end else begin
            instr_q    <= NOP_INSTR;
            addr_err_q <= 1'b1;
            par_err_q  <= 1'b0;
          end
        end else if (bus.instruction_ack) begin
          // instruction keeps its last value once consumed
          valid_q    <= 1'b0;
          addr_err_q <= 1'b0;
          par_err_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.fetch_ready       = fetch_ready;
  assign bus.instruction       = instr_q;
  assign bus.instruction_valid = valid_q;
  assign bus.addr_error        = addr_err_q;
  assign bus.parity_error      = par_err_q;

endmodule

// File: tb/tb_instruction_memory_param.sv
// Bench for instruction_memory_param (DEPTH=768): directed sequences, a vector table and a random fetch run.
module tb_instruction_memory_param;
  localparam int          IW    = 12;
  localparam int          AW    = 10;
  localparam int          DEPTH = 768;
  localparam logic [11:0] NOP   = 12'h000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_memory_param_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus_if ();

  instruction_memory_param #(
    .INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset_instruction(rst),
    .bus(bus_if)
  );

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] model_mem [1024];
  bit            model_written [1024];
  int            wr_list [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    logic          aerr;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Assumes load_en is already high and the DUT is in LOAD.
  task automatic do_write(input int a, input int d);
    logic [31:0] av;
    logic [31:0] dv;
    av = a;
    dv = d;
    bus_if.load_we   = 1'b1;
    bus_if.load_addr = av[AW-1:0];
    bus_if.load_data = dv[IW-1:0];
    #1;
    chk("load_ready", {31'b0, bus_if.fetch_ready}, 0);
    tick;
    bus_if.load_we = 1'b0;
    if (a < DEPTH) begin
      if (!model_written[a]) begin
        model_written[a] = 1'b1;
        wr_list.push_back(a);
      end
      model_mem[a] = dv[IW-1:0];
    end
  endtask

  initial begin
    bit            ev;
    bit            ea;
    bit            er;
    logic [IW-1:0] ei;
    logic [31:0]   av;
    int            a;
    bit            req;
    bit            ack;

    vecs[0] = '{10'h155, 12'hABC, 1'b0};
    vecs[1] = '{10'h300, NOP,     1'b1};
    vecs[2] = '{10'h001, 12'h111, 1'b0};
    vecs[3] = '{10'h2FF, 12'h3C3, 1'b0};
    vecs[4] = '{10'h3FF, NOP,     1'b1};
    vecs[5] = '{10'h000, 12'h5A5, 1'b0};
    vecs[6] = '{10'h002, 12'h222, 1'b0};

    rst = 1'b1;
    bus_if.load_en = 0; bus_if.load_we = 0; bus_if.load_addr = '0; bus_if.load_data = '0;
    bus_if.fetch_req = 0; bus_if.instruction_addr_pc = 10'h155; bus_if.instruction_ack = 0;
    #2;
    chk("rst_instr", {20'b0, bus_if.instruction}, 32'h000);
    chk("rst_valid", {31'b0, bus_if.instruction_valid}, 0);
    chk("rst_aerr", {31'b0, bus_if.addr_error}, 0);
    chk("rst_perr", {31'b0, bus_if.parity_error}, 0);
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'b0, bus_if.fetch_ready}, 1);

    // program load, including one out-of-range write
    bus_if.load_en = 1'b1;
    #1;
    chk("loadreq_ready", {31'b0, bus_if.fetch_ready}, 0);
    tick;
    do_write(12'h155, 12'hABC);
    do_write(12'h001, 12'h111);
    do_write(12'h002, 12'h222);
    do_write(12'h000, 12'h5A5);
    do_write(12'h2FF, 12'h3C3);
    do_write(12'h300, 12'hFFF);
    bus_if.load_en = 1'b0;
    tick;

    // single fetch, one-cycle latency, then ack
    bus_if.fetch_req = 1'b1; bus_if.instruction_addr_pc = 10'h155;
    #1;
    chk("f1_ready", {31'b0, bus_if.fetch_ready}, 1);
    tick;
    bus_if.fetch_req = 1'b0;
    chk("f1_valid", {31'b0, bus_if.instruction_valid}, 1);
    chk("f1_instr", {20'b0, bus_if.instruction}, 32'hABC);
    chk("f1_aerr", {31'b0, bus_if.addr_error}, 0);
    bus_if.instruction_ack = 1'b1;
    tick;
    bus_if.instruction_ack = 1'b0;
    chk("ack_valid", {31'b0, bus_if.instruction_valid}, 0);
    chk("ack_hold_instr", {20'b0, bus_if.instruction}, 32'hABC);

    // backpressure then ack+fetch in the same cycle
    bus_if.fetch_req = 1'b1; bus_if.instruction_addr_pc = 10'h001;
    tick;
    bus_if.instruction_addr_pc = 10'h002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {31'b0, bus_if.fetch_ready}, 0);
      tick;
      chk("bp_instr", {20'b0, bus_if.instruction}, 32'h111);
      chk("bp_valid", {31'b0, bus_if.instruction_valid}, 1);
    end
    bus_if.instruction_ack = 1'b1;
    #1;
    chk("bb_ready", {31'b0, bus_if.fetch_ready}, 1);
    tick;
    chk("bb_instr", {20'b0, bus_if.instruction}, 32'h222);
    chk("bb_valid", {31'b0, bus_if.instruction_valid}, 1);

    // back-to-back vector table, ack held high
    foreach (vecs[i]) begin
      bus_if.fetch_req = 1'b1;
      bus_if.instruction_ack = 1'b1;
      bus_if.instruction_addr_pc = vecs[i].addr;
      tick;
      chk("tbl_valid", {31'b0, bus_if.instruction_valid}, 1);
      chk("tbl_instr", {20'b0, bus_if.instruction}, {20'b0, vecs[i].instr});
      chk("tbl_aerr", {31'b0, bus_if.addr_error}, {31'b0, vecs[i].aerr});
    end
    bus_if.fetch_req = 1'b0;
    tick;
    bus_if.instruction_ack = 1'b0;
    chk("tbl_drain_valid", {31'b0, bus_if.instruction_valid}, 0);
    chk("tbl_drain_aerr", {31'b0, bus_if.addr_error}, 0);

    // load request while a word is pending
    bus_if.fetch_req = 1'b1; bus_if.instruction_addr_pc = 10'h155;
    tick;
    chk("ms_valid_pre", {31'b0, bus_if.instruction_valid}, 1);
    bus_if.load_en = 1'b1;
    bus_if.instruction_addr_pc = 10'h001;
    #1;
    chk("ms_ready_req", {31'b0, bus_if.fetch_ready}, 0);
    tick;
    chk("ms_valid_drop", {31'b0, bus_if.instruction_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ms_ready_load", {31'b0, bus_if.fetch_ready}, 0);
      chk("ms_valid_load", {31'b0, bus_if.instruction_valid}, 0);
      tick;
    end
    bus_if.load_en = 1'b0;
    bus_if.fetch_req = 1'b0;
    tick;
    chk("ms_ready_run", {31'b0, bus_if.fetch_ready}, 1);

    // reset asserted in the acceptance cycle
    bus_if.fetch_req = 1'b1; bus_if.instruction_addr_pc = 10'h155;
    #1;
    chk("rf_ready", {31'b0, bus_if.fetch_ready}, 1);
    rst = 1'b1;
    #1;
    chk("rf_valid_rst", {31'b0, bus_if.instruction_valid}, 0);
    chk("rf_instr_rst", {20'b0, bus_if.instruction}, {20'b0, NOP});
    tick; tick;
    rst = 1'b0;
    bus_if.fetch_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rf_valid_after", {31'b0, bus_if.instruction_valid}, 0);
    end
    bus_if.fetch_req = 1'b1;
    tick;
    bus_if.fetch_req = 1'b0;
    chk("rf_keep_valid", {31'b0, bus_if.instruction_valid}, 1);
    chk("rf_keep_instr", {20'b0, bus_if.instruction}, 32'hABC);
    bus_if.instruction_ack = 1'b1;
    tick;
    bus_if.instruction_ack = 1'b0;

    // random program load
    bus_if.load_en = 1'b1;
    tick;
    for (int i = 0; i < 30; i++) begin
      do_write(int'($urandom_range(0, 1023)), int'($urandom_range(0, 4095)));
    end
    bus_if.load_en = 1'b0;
    tick;

    // random fetch/ack traffic against the model
    ev = 1'b0; ea = 1'b0; ei = NOP;
    for (int c = 0; c < 300; c++) begin
      req = ($urandom_range(0, 99) < 70);
      ack = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(DEPTH, 1023));
      else a = wr_list[$urandom_range(0, wr_list.size() - 1)];
      av = a;
      bus_if.fetch_req = req;
      bus_if.instruction_ack = ack;
      bus_if.instruction_addr_pc = av[AW-1:0];
      #1;
      er = !ev || ack;
      chk("rnd_ready", {31'b0, bus_if.fetch_ready}, {31'b0, er});
      if (req && er) begin
        ev = 1'b1;
        if (a < DEPTH) begin
          ei = model_mem[a];
          ea = 1'b0;
        end else begin
          ei = NOP;
          ea = 1'b1;
        end
      end else if (ack) begin
        ev = 1'b0;
        ea = 1'b0;
      end
      tick;
      chk("rnd_valid", {31'b0, bus_if.instruction_valid}, {31'b0, ev});
      chk("rnd_aerr", {31'b0, bus_if.addr_error}, {31'b0, ea});
      chk("rnd_perr", {31'b0, bus_if.parity_error}, 0);
      if (ev) chk("rnd_instr", {20'b0, bus_if.instruction}, {20'b0, ei});
    end
    bus_if.fetch_req = 1'b0;
    bus_if.instruction_ack = 1'b1;
    tick;
    bus_if.instruction_ack = 1'b0;
    chk("end_valid", {31'b0, bus_if.instruction_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
